// File: rtl/preadd_mac_accum_round.sv
`default_nettype none
// ============================================================================
// Module   : preadd_mac_accum_round
// Purpose  : Accumulates NACC signed products into one wide sum, then rounds,
//            arithmetic-right-shifts by SHIFT and saturates to OW bits.
//            The result is presented on a valid/ready output register.
// Options  : ACC_ROUND_CONV_EN - convergent (half-to-even) rounding when
//            defined; round half up (toward +inf on ties) otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module preadd_mac_accum_round #(
  parameter int PW    = 48,
  parameter int NACC  = 8,
  parameter int SHIFT = 15,
  parameter int OW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc_clr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [OW-1:0] out_data_o,
  output logic          out_sat_o,
  output logic [15:0]   sat_cnt_o
);

  // Accumulator holds NACC full-scale products without overflow.
  localparam int ACCW = PW + $clog2(NACC);
  localparam int CW   = (NACC > 1) ? $clog2(NACC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NACC - 1);

  // Rounding and saturation constants, all at ACCW+1 bits.
  localparam logic [ACCW:0]        ONE  = {{ACCW{1'b0}}, 1'b1};
  localparam logic signed [ACCW:0] HALF = $signed(ONE << (SHIFT - 1));
  localparam logic signed [ACCW:0] MAXV = $signed((ONE << (OW - 1)) - ONE);
  localparam logic signed [ACCW:0] MINV = -$signed(ONE << (OW - 1));

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [OW-1:0]          out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [15:0]            sat_cnt_q, sat_cnt_d;

  logic                   w_accept;
  logic                   w_last;
  logic signed [PW-1:0]   w_in_s;
  logic signed [ACCW-1:0] w_in_ext;
  logic signed [ACCW-1:0] w_base_acc;
  logic [CW-1:0]          w_base_cnt;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW:0]   w_sum_x;
  logic signed [ACCW:0]   w_q_hu;
  logic signed [ACCW:0]   w_q;
  logic                   w_hi;
  logic                   w_lo;
  logic [OW-1:0]          w_res;

  // The stage can take a sample whenever the output register is free or
  // being emptied this cycle.
  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign w_accept   = in_valid_i & in_ready_o;

  // A clear in the same cycle as an accept makes that sample the first of a
  // fresh frame, so the add starts from zero.
  assign w_base_acc = acc_clr_i ? '0 : acc_q;
  assign w_base_cnt = acc_clr_i ? '0 : cnt_q;
  assign w_last     = (w_base_cnt == CNT_LAST);

  assign w_in_s   = in_data_i;
  assign w_in_ext = ACCW'(w_in_s);
  assign w_sum    = w_base_acc + w_in_ext;

  // One extra bit of headroom so adding the rounding half cannot wrap.
  assign w_sum_x = (ACCW + 1)'(w_sum);
  assign w_q_hu  = (w_sum_x + HALF) >>> SHIFT;

`ifdef ACC_ROUND_CONV_EN
  logic                 w_tie;
  logic signed [ACCW:0] w_trunc;
  assign w_tie   = (w_sum_x[SHIFT-1:0] == HALF[SHIFT-1:0]);
  assign w_trunc = w_sum_x >>> SHIFT;
  // On an exact tie round to the even neighbour: bump only if truncation
  // left an odd value.
  assign w_q     = w_tie ? (w_trunc + (ACCW + 1)'(w_sum_x[SHIFT])) : w_q_hu;
`else
  assign w_q     = w_q_hu;
`endif

  assign w_hi  = (w_q > MAXV);
  assign w_lo  = (w_q < MINV);
  assign w_res = w_hi ? MAXV[OW-1:0] : (w_lo ? MINV[OW-1:0] : w_q[OW-1:0]);

  // Next-state: accumulate, close frames, and manage the output register.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_cnt_d   = sat_cnt_q;

    if (w_accept) begin
      if (w_last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = w_sum;
        cnt_d = w_base_cnt + CW'(1);
      end
    end else if (acc_clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end

    if (w_accept && w_last) begin
      out_valid_d = 1'b1;
      out_data_d  = w_res;
      out_sat_d   = w_hi | w_lo;
      if ((w_hi | w_lo) && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;
  assign sat_cnt_o   = sat_cnt_q;

endmodule
`default_nettype wire
